// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the MIPS control path: opcodes, functs, ALU codes,
// datapath select enums and the trap vector addresses.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  localparam logic [31:0] VEC_IRQ = 32'h8000_0004;
  localparam logic [31:0] VEC_EXC = 32'h8000_0008;

  typedef enum logic [2:0] {
    PCSRC_PC4    = 3'd0,
    PCSRC_BRANCH = 3'd1,
    PCSRC_JUMP   = 3'd2,
    PCSRC_RS     = 3'd3,
    PCSRC_IRQ    = 3'd4,
    PCSRC_EXC    = 3'd5
  } pcsrc_e;

  typedef enum logic [1:0] {
    REGDST_RD = 2'd0,
    REGDST_RT = 2'd1,
    REGDST_RA = 2'd2,
    REGDST_XP = 2'd3
  } regdst_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'd0,
    M2R_MEM = 2'd1,
    M2R_PC4 = 2'd2
  } memtoreg_e;

  typedef struct packed {
    pcsrc_e     pcsrc;
    regdst_e    regdst;
    logic       regwr;
    logic       alusrc1;
    logic       alusrc2;
    logic [5:0] alufun;
    logic       sign;
    logic       memwr;
    logic       memrd;
    memtoreg_e  memtoreg;
    logic       extop;
    logic       luop;
  } ctrl_t;

endpackage

// File: rtl/cpu_decode.sv
// Pure combinational opcode/funct decode; flags encodings it does not know.
module cpu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_undef
);

  always_comb begin
    o_ctrl        = '0;
    o_ctrl.alufun = ALU_ADD;
    o_ctrl.extop  = 1'b1;
    o_undef       = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.regdst = REGDST_RD;
        o_ctrl.regwr  = 1'b1;
        case (i_funct)
          FN_ADD:  begin o_ctrl.alufun = ALU_ADD; o_ctrl.sign = 1'b1; end
          FN_ADDU: o_ctrl.alufun = ALU_ADD;
          FN_SUB:  begin o_ctrl.alufun = ALU_SUB; o_ctrl.sign = 1'b1; end
          FN_SUBU: o_ctrl.alufun = ALU_SUB;
          FN_AND:  o_ctrl.alufun = ALU_AND;
          FN_OR:   o_ctrl.alufun = ALU_OR;
          FN_XOR:  o_ctrl.alufun = ALU_XOR;
          FN_NOR:  o_ctrl.alufun = ALU_NOR;
          FN_SLT:  begin o_ctrl.alufun = ALU_LT; o_ctrl.sign = 1'b1; end
          FN_SLTU: o_ctrl.alufun = ALU_LT;
          FN_SLL:  begin o_ctrl.alufun = ALU_SLL; o_ctrl.alusrc1 = 1'b1; end
          FN_SRL:  begin o_ctrl.alufun = ALU_SRL; o_ctrl.alusrc1 = 1'b1; end
          FN_SRA:  begin o_ctrl.alufun = ALU_SRA; o_ctrl.alusrc1 = 1'b1; end
          FN_JR:   begin o_ctrl.pcsrc = PCSRC_RS; o_ctrl.regwr = 1'b0; end
          FN_JALR: begin o_ctrl.pcsrc = PCSRC_RS; o_ctrl.memtoreg = M2R_PC4; end
          default: begin o_ctrl.regwr = 1'b0; o_undef = 1'b1; end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI: begin
        o_ctrl.alusrc2 = 1'b1;
        o_ctrl.regdst  = REGDST_RT;
        o_ctrl.regwr   = 1'b1;
        o_ctrl.sign    = (i_op == OP_ADDI) || (i_op == OP_SLTI);
        if (i_op == OP_SLTI || i_op == OP_SLTIU) o_ctrl.alufun = ALU_LT;
        if (i_op == OP_ANDI) begin
          o_ctrl.alufun = ALU_AND;
          o_ctrl.extop  = 1'b0;
        end
      end
      OP_LW: begin
        o_ctrl.alusrc2  = 1'b1;
        o_ctrl.memrd    = 1'b1;
        o_ctrl.memtoreg = M2R_MEM;
        o_ctrl.regdst   = REGDST_RT;
        o_ctrl.regwr    = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alusrc2 = 1'b1;
        o_ctrl.memwr   = 1'b1;
      end
      // The datapath feeds $0 as operand A, so ADD yields Imm16<<16.
      OP_LUI: begin
        o_ctrl.luop    = 1'b1;
        o_ctrl.alusrc2 = 1'b1;
        o_ctrl.regdst  = REGDST_RT;
        o_ctrl.regwr   = 1'b1;
      end
      OP_BEQ:  begin o_ctrl.pcsrc = PCSRC_BRANCH; o_ctrl.sign = 1'b1; o_ctrl.alufun = ALU_EQ;  end
      OP_BNE:  begin o_ctrl.pcsrc = PCSRC_BRANCH; o_ctrl.sign = 1'b1; o_ctrl.alufun = ALU_NEQ; end
      OP_BLEZ: begin o_ctrl.pcsrc = PCSRC_BRANCH; o_ctrl.sign = 1'b1; o_ctrl.alufun = ALU_LEZ; end
      OP_BGTZ: begin o_ctrl.pcsrc = PCSRC_BRANCH; o_ctrl.sign = 1'b1; o_ctrl.alufun = ALU_GTZ; end
      OP_BLTZ: begin o_ctrl.pcsrc = PCSRC_BRANCH; o_ctrl.sign = 1'b1; o_ctrl.alufun = ALU_LTZ; end
      OP_J:    o_ctrl.pcsrc = PCSRC_JUMP;
      OP_JAL: begin
        o_ctrl.pcsrc    = PCSRC_JUMP;
        o_ctrl.regdst   = REGDST_RA;
        o_ctrl.memtoreg = M2R_PC4;
        o_ctrl.regwr    = 1'b1;
      end
      default: o_undef = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Main decoder: instruction field split, registered IRQ sample and the
// reset > interrupt > exception > normal-decode override chain.
module cpu_control
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruct,
  input  logic        PC,
  input  logic        IRQ,
  output logic [25:0] JT,
  output logic [15:0] Imm16,
  output logic [4:0]  Shamt,
  output logic [4:0]  Rd,
  output logic [4:0]  Rt,
  output logic [4:0]  Rs,
  output logic [2:0]  PCSrc,
  output logic [1:0]  RegDst,
  output logic        RegWr,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [5:0]  ALUFun,
  output logic        Sign,
  output logic        MemWr,
  output logic        MemRd,
  output logic [1:0]  MemToReg,
  output logic        EXTOp,
  output logic        LUOp
);

  logic  r_irq;
  logic  w_undef;
  logic  w_take_irq;
  ctrl_t w_dec;
  ctrl_t w_ctrl;

  assign JT    = Instruct[25:0];
  assign Imm16 = Instruct[15:0];
  assign Shamt = Instruct[10:6];
  assign Rd    = Instruct[15:11];
  assign Rt    = Instruct[20:16];
  assign Rs    = Instruct[25:21];

  cpu_decode u_decode (
    .i_op    (Instruct[31:26]),
    .i_funct (Instruct[5:0]),
    .o_ctrl  (w_dec),
    .o_undef (w_undef)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= IRQ;
  end

  // Kernel mode masks interrupts and suppresses exception entry.
  assign w_take_irq = r_irq & ~PC;

  always_comb begin
    w_ctrl = w_dec;
    if (reset) begin
      w_ctrl.pcsrc = PCSRC_PC4;
      w_ctrl.regwr = 1'b0;
      w_ctrl.memwr = 1'b0;
      w_ctrl.memrd = 1'b0;
    end else if (w_take_irq || (w_undef && !PC)) begin
      w_ctrl.pcsrc    = w_take_irq ? PCSRC_IRQ : PCSRC_EXC;
      w_ctrl.regdst   = REGDST_XP;
      w_ctrl.memtoreg = M2R_PC4;
      w_ctrl.regwr    = 1'b1;
      w_ctrl.memwr    = 1'b0;
      w_ctrl.memrd    = 1'b0;
    end else if (w_undef) begin
      w_ctrl.pcsrc = PCSRC_PC4;
      w_ctrl.regwr = 1'b0;
      w_ctrl.memwr = 1'b0;
      w_ctrl.memrd = 1'b0;
    end
  end

  assign PCSrc    = w_ctrl.pcsrc;
  assign RegDst   = w_ctrl.regdst;
  assign RegWr    = w_ctrl.regwr;
  assign ALUSrc1  = w_ctrl.alusrc1;
  assign ALUSrc2  = w_ctrl.alusrc2;
  assign ALUFun   = w_ctrl.alufun;
  assign Sign     = w_ctrl.sign;
  assign MemWr    = w_ctrl.memwr;
  assign MemRd    = w_ctrl.memrd;
  assign MemToReg = w_ctrl.memtoreg;
  assign EXTOp    = w_ctrl.extop;
  assign LUOp     = w_ctrl.luop;

endmodule

// File: tb/tb_cpu_control.sv
// Directed scenarios plus randomized instruction stream checked against a
// mnemonic-level reference model of the control decoder.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruct;
  logic        PC;
  logic        IRQ;
  logic [25:0] JT;
  logic [15:0] Imm16;
  logic [4:0]  Shamt, Rd, Rt, Rs;
  logic [2:0]  PCSrc;
  logic [1:0]  RegDst, MemToReg;
  logic        RegWr, ALUSrc1, ALUSrc2, Sign, MemWr, MemRd, EXTOp, LUOp;
  logic [5:0]  ALUFun;

  int checks = 0;
  int errors = 0;
  logic exp_q = 1'b0;

  cpu_control dut (
    .clk(clk), .reset(reset), .Instruct(Instruct), .PC(PC), .IRQ(IRQ),
    .JT(JT), .Imm16(Imm16), .Shamt(Shamt), .Rd(Rd), .Rt(Rt), .Rs(Rs),
    .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .ALUFun(ALUFun), .Sign(Sign), .MemWr(MemWr),
    .MemRd(MemRd), .MemToReg(MemToReg), .EXTOp(EXTOp), .LUOp(LUOp)
  );

  always #5 clk = ~clk;

  wire [20:0] w_out = {PCSrc, RegDst, RegWr, ALUSrc1, ALUSrc2, ALUFun, Sign,
                       MemWr, MemRd, MemToReg, EXTOp, LUOp};

  // Reference: per-mnemonic control table, then trap/reset overrides.
  function automatic logic [20:0] model(input logic [31:0] ins, input logic pc,
                                        input logic q, input logic rst);
    logic [5:0] op, f, fn;
    logic [2:0] pcs;
    logic [1:0] rd, m2r;
    logic rw, a1, a2, sg, mw, mr, ex, lu, undef;
    op = ins[31:26]; f = ins[5:0];
    pcs = 3'd0; rd = 2'd0; m2r = 2'd0; fn = 6'b000000;
    rw = 0; a1 = 0; a2 = 0; sg = 0; mw = 0; mr = 0; ex = 1; lu = 0; undef = 0;
    if (op == 6'h00) begin
      case (f)
        6'h20: begin rw = 1; sg = 1; end
        6'h21: rw = 1;
        6'h22: begin rw = 1; sg = 1; fn = 6'b000001; end
        6'h23: begin rw = 1; fn = 6'b000001; end
        6'h24: begin rw = 1; fn = 6'b011000; end
        6'h25: begin rw = 1; fn = 6'b011110; end
        6'h26: begin rw = 1; fn = 6'b010110; end
        6'h27: begin rw = 1; fn = 6'b010001; end
        6'h2A: begin rw = 1; sg = 1; fn = 6'b110101; end
        6'h2B: begin rw = 1; fn = 6'b110101; end
        6'h00: begin rw = 1; a1 = 1; fn = 6'b100000; end
        6'h02: begin rw = 1; a1 = 1; fn = 6'b100001; end
        6'h03: begin rw = 1; a1 = 1; fn = 6'b100011; end
        6'h08: pcs = 3'd3;
        6'h09: begin pcs = 3'd3; m2r = 2'd2; rw = 1; end
        default: undef = 1;
      endcase
    end else begin
      case (op)
        6'h08: begin a2 = 1; rd = 1; rw = 1; sg = 1; end
        6'h09: begin a2 = 1; rd = 1; rw = 1; end
        6'h0C: begin a2 = 1; rd = 1; rw = 1; fn = 6'b011000; ex = 0; end
        6'h0A: begin a2 = 1; rd = 1; rw = 1; sg = 1; fn = 6'b110101; end
        6'h0B: begin a2 = 1; rd = 1; rw = 1; fn = 6'b110101; end
        6'h23: begin a2 = 1; mr = 1; m2r = 1; rd = 1; rw = 1; end
        6'h2B: begin a2 = 1; mw = 1; end
        6'h0F: begin lu = 1; a2 = 1; rd = 1; rw = 1; end
        6'h04: begin pcs = 1; sg = 1; fn = 6'b110011; end
        6'h05: begin pcs = 1; sg = 1; fn = 6'b110001; end
        6'h06: begin pcs = 1; sg = 1; fn = 6'b111101; end
        6'h07: begin pcs = 1; sg = 1; fn = 6'b111111; end
        6'h01: begin pcs = 1; sg = 1; fn = 6'b111011; end
        6'h02: pcs = 2;
        6'h03: begin pcs = 2; rd = 2; m2r = 2; rw = 1; end
        default: undef = 1;
      endcase
    end
    if (rst) begin
      pcs = 0; rw = 0; mw = 0; mr = 0;
    end else if (q && !pc) begin
      pcs = 4; rd = 3; m2r = 2; rw = 1; mw = 0; mr = 0;
    end else if (undef && !pc) begin
      pcs = 5; rd = 3; m2r = 2; rw = 1; mw = 0; mr = 0;
    end else if (undef) begin
      pcs = 0; rw = 0; mw = 0; mr = 0;
    end
    return {pcs, rd, rw, a1, a2, fn, sg, mw, mr, m2r, ex, lu};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 4) begin
      r[31:26] = 6'h00;
      case ($urandom_range(0, 15))
        0: r[5:0] = 6'h20;  1: r[5:0] = 6'h21;  2: r[5:0] = 6'h22;
        3: r[5:0] = 6'h23;  4: r[5:0] = 6'h24;  5: r[5:0] = 6'h25;
        6: r[5:0] = 6'h26;  7: r[5:0] = 6'h27;  8: r[5:0] = 6'h2A;
        9: r[5:0] = 6'h2B;  10: r[5:0] = 6'h00; 11: r[5:0] = 6'h02;
        12: r[5:0] = 6'h03; 13: r[5:0] = 6'h08; 14: r[5:0] = 6'h09;
        default: r[5:0] = r[5:0];
      endcase
    end else if (sel < 9) begin
      case ($urandom_range(0, 14))
        0: r[31:26] = 6'h01;  1: r[31:26] = 6'h02;  2: r[31:26] = 6'h03;
        3: r[31:26] = 6'h04;  4: r[31:26] = 6'h05;  5: r[31:26] = 6'h06;
        6: r[31:26] = 6'h07;  7: r[31:26] = 6'h08;  8: r[31:26] = 6'h09;
        9: r[31:26] = 6'h0A;  10: r[31:26] = 6'h0B; 11: r[31:26] = 6'h0C;
        12: r[31:26] = 6'h0F; 13: r[31:26] = 6'h23;
        default: r[31:26] = 6'h2B;
      endcase
    end
    return r;
  endfunction

  // One clock: the edge samples the current IRQ, then new inputs settle,
  // outputs are observed on the falling edge.
  task automatic apply(input logic [31:0] ins, input logic pc, input logic irq);
    @(posedge clk);
    exp_q = reset ? 1'b0 : IRQ;
    #1;
    Instruct = ins; PC = pc; IRQ = irq;
    @(negedge clk);
    $display("txn ins=%h pc=%b irq=%b -> pcsrc=%0d regdst=%0d regwr=%b alufun=%b",
             Instruct, PC, IRQ, PCSrc, RegDst, RegWr, ALUFun);
  endtask

  task automatic test_reset();
    logic [31:0] lw;
    lw = {6'h23, 5'd4, 5'd5, 16'h0010};
    reset = 1'b1; Instruct = lw; PC = 1'b0; IRQ = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({PCSrc, RegWr, MemWr, MemRd} !== 6'b0) begin
      errors++;
      $display("FAIL reset_gate: pcsrc/regwr/memwr/memrd=%b required 000000",
               {PCSrc, RegWr, MemWr, MemRd});
    end
    checks++;
    if ({Rs, Rt, Imm16} !== {5'd4, 5'd5, 16'h0010}) begin
      errors++;
      $display("FAIL reset_fields: rs=%0d rt=%0d imm=%h required 4 5 0010", Rs, Rt, Imm16);
    end
    IRQ = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({MemRd, MemToReg, RegWr, RegDst, ALUSrc2, PCSrc} !== {1'b1, 2'd1, 1'b1, 2'd1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_release_lw: memrd=%b m2r=%0d regwr=%b regdst=%0d alusrc2=%b pcsrc=%0d required 1 1 1 1 1 0",
               MemRd, MemToReg, RegWr, RegDst, ALUSrc2, PCSrc);
    end
  endtask

  task automatic test_rtype();
    apply(32'h01E39020, 1'b0, 1'b0);
    checks++;
    if ({Rs, Rt, Rd, RegDst, RegWr, ALUFun, Sign} !== {5'd15, 5'd3, 5'd18, 2'd0, 1'b1, 6'b000000, 1'b1}) begin
      errors++;
      $display("FAIL rtype_add: rs=%0d rt=%0d rd=%0d regdst=%0d regwr=%b alufun=%b sign=%b required 15 3 18 0 1 000000 1",
               Rs, Rt, Rd, RegDst, RegWr, ALUFun, Sign);
    end
    apply(32'h01E39021, 1'b0, 1'b0);
    checks++;
    if ({Sign, RegWr} !== 2'b01) begin
      errors++;
      $display("FAIL rtype_addu: sign=%b regwr=%b required 0 1", Sign, RegWr);
    end
    apply(32'h00000040, 1'b0, 1'b0);
    checks++;
    if ({Shamt, ALUSrc1, ALUFun, RegWr} !== {5'd1, 1'b1, 6'b100000, 1'b1}) begin
      errors++;
      $display("FAIL rtype_sll: shamt=%0d alusrc1=%b alufun=%b regwr=%b required 1 1 100000 1",
               Shamt, ALUSrc1, ALUFun, RegWr);
    end
  endtask

  task automatic test_itype();
    apply({6'h2B, 5'd1, 5'd2, 16'hFFF0}, 1'b0, 1'b0);
    checks++;
    if ({MemWr, RegWr, MemRd, ALUSrc2} !== 4'b1001) begin
      errors++;
      $display("FAIL itype_sw: memwr=%b regwr=%b memrd=%b alusrc2=%b required 1 0 0 1",
               MemWr, RegWr, MemRd, ALUSrc2);
    end
    apply({6'h0F, 5'd0, 5'd7, 16'h1234}, 1'b0, 1'b0);
    checks++;
    if ({LUOp, RegWr, RegDst, ALUSrc2, ALUFun} !== {1'b1, 1'b1, 2'd1, 1'b1, 6'b000000}) begin
      errors++;
      $display("FAIL itype_lui: luop=%b regwr=%b regdst=%0d alusrc2=%b alufun=%b required 1 1 1 1 000000",
               LUOp, RegWr, RegDst, ALUSrc2, ALUFun);
    end
    apply({6'h0C, 5'd3, 5'd4, 16'h00FF}, 1'b0, 1'b0);
    checks++;
    if ({EXTOp, ALUFun, RegWr, RegDst} !== {1'b0, 6'b011000, 1'b1, 2'd1}) begin
      errors++;
      $display("FAIL itype_andi: extop=%b alufun=%b regwr=%b regdst=%0d required 0 011000 1 1",
               EXTOp, ALUFun, RegWr, RegDst);
    end
  endtask

  task automatic test_branch_jump();
    logic [5:0] ops [5];
    logic [5:0] fns [5];
    ops = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
    fns = '{6'b110011, 6'b110001, 6'b111101, 6'b111111, 6'b111011};
    for (int i = 0; i < 5; i++) begin
      apply({ops[i], 5'd2, 5'd0, 16'h0004}, 1'b0, 1'b0);
      checks++;
      if ({PCSrc, ALUFun, RegWr, Sign} !== {3'd1, fns[i], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL branch_op%h: pcsrc=%0d alufun=%b regwr=%b sign=%b required 1 %b 0 1",
                 ops[i], PCSrc, ALUFun, RegWr, Sign, fns[i]);
      end
    end
    apply({6'h02, 26'h0123456}, 1'b0, 1'b0);
    checks++;
    if ({PCSrc, RegWr, JT} !== {3'd2, 1'b0, 26'h0123456}) begin
      errors++;
      $display("FAIL jump_j: pcsrc=%0d regwr=%b jt=%h required 2 0 0123456", PCSrc, RegWr, JT);
    end
    apply({6'h03, 26'h0000100}, 1'b0, 1'b0);
    checks++;
    if ({PCSrc, RegDst, MemToReg, RegWr} !== {3'd2, 2'd2, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL jump_jal: pcsrc=%0d regdst=%0d m2r=%0d regwr=%b required 2 2 2 1",
               PCSrc, RegDst, MemToReg, RegWr);
    end
    apply({6'h00, 5'd31, 15'd0, 6'h08}, 1'b0, 1'b0);
    checks++;
    if ({PCSrc, RegWr} !== {3'd3, 1'b0}) begin
      errors++;
      $display("FAIL jump_jr: pcsrc=%0d regwr=%b required 3 0", PCSrc, RegWr);
    end
    apply({6'h00, 5'd9, 5'd0, 5'd31, 5'd0, 6'h09}, 1'b0, 1'b0);
    checks++;
    if ({PCSrc, RegWr, RegDst, MemToReg} !== {3'd3, 1'b1, 2'd0, 2'd2}) begin
      errors++;
      $display("FAIL jump_jalr: pcsrc=%0d regwr=%b regdst=%0d m2r=%0d required 3 1 0 2",
               PCSrc, RegWr, RegDst, MemToReg);
    end
  endtask

  task automatic test_exception();
    apply(32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if ({PCSrc, RegDst, RegWr, MemToReg, MemWr, MemRd} !== {3'd5, 2'd3, 1'b1, 2'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exc_user: pcsrc=%0d regdst=%0d regwr=%b m2r=%0d memwr=%b memrd=%b required 5 3 1 2 0 0",
               PCSrc, RegDst, RegWr, MemToReg, MemWr, MemRd);
    end
    apply(32'hFFFF_FFFF, 1'b1, 1'b0);
    checks++;
    if ({PCSrc, RegWr, MemWr, MemRd} !== 6'b0) begin
      errors++;
      $display("FAIL exc_kernel: pcsrc=%0d regwr=%b memwr=%b memrd=%b required 0 0 0 0",
               PCSrc, RegWr, MemWr, MemRd);
    end
  endtask

  task automatic test_interrupt();
    apply(32'h01E39020, 1'b0, 1'b1);
    checks++;
    if (PCSrc !== 3'd0 || RegDst !== 2'd0) begin
      errors++;
      $display("FAIL irq_early: pcsrc=%0d regdst=%0d required 0 0", PCSrc, RegDst);
    end
    apply(32'h01E39020, 1'b0, 1'b1);
    checks++;
    if ({PCSrc, RegDst, MemToReg, RegWr, MemWr, MemRd} !== {3'd4, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL irq_taken: pcsrc=%0d regdst=%0d m2r=%0d regwr=%b memwr=%b memrd=%b required 4 3 2 1 0 0",
               PCSrc, RegDst, MemToReg, RegWr, MemWr, MemRd);
    end
    apply({6'h23, 5'd1, 5'd2, 16'h0008}, 1'b1, 1'b1);
    checks++;
    if ({PCSrc, RegDst, MemToReg, MemRd} !== {3'd0, 2'd1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL irq_masked: pcsrc=%0d regdst=%0d m2r=%0d memrd=%b required 0 1 1 1",
               PCSrc, RegDst, MemToReg, MemRd);
    end
    apply(32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (PCSrc !== 3'd4) begin
      errors++;
      $display("FAIL irq_over_exc: pcsrc=%0d required 4", PCSrc);
    end
    apply(32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [20:0] exp_v;
    for (int n = 0; n < 400; n++) begin
      ins = rand_instr();
      apply(ins, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      exp_v = model(Instruct, PC, exp_q, reset);
      checks++;
      if (w_out !== exp_v) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: ins=%h pc=%b irq_q=%b got %b required %b",
                 n, Instruct, PC, exp_q, w_out, exp_v);
      end
      checks++;
      if ({JT, Rs, Rt, Rd, Shamt, Imm16} !==
          {ins[25:0], ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[15:0]}) begin
        errors++;
        $display("FAIL rand_fields[%0d]: ins=%h jt=%h rs=%0d rt=%0d rd=%0d shamt=%0d imm=%h",
                 n, ins, JT, Rs, Rt, Rd, Shamt, Imm16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch_jump();
    test_exception();
    test_interrupt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
Main decoder for the single-cycle MIPS datapath. It splits the 32-bit instruction into its fields and produces every datapath control signal: PC source, register-file write, ALU operand selects and function, memory strobes, write-back select and immediate extension. It also arbitrates external interrupts and undefined-instruction exceptions, gated by the kernel-mode bit (PC[31]). It sits between the instruction memory and the datapath.

Parameters:
None. Encodings are constants in the shared package.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Instruct  in  32  current instruction
PC  in  1  kernel-mode bit (PC[31]); 1 = kernel, interrupts masked
IRQ  in  1  external interrupt request, level
JT  out  26  Instruct[25:0]
Imm16  out  16  Instruct[15:0]
Shamt  out  5  Instruct[10:6]
Rd  out  5  Instruct[15:11]
Rt  out  5  Instruct[20:16]
Rs  out  5  Instruct[25:21]
PCSrc  out  3  0 PC+4, 1 branch, 2 jump target, 3 Rs (jr/jalr), 4 interrupt vector 0x80000004, 5 exception vector 0x80000008
RegDst  out  2  0 Rd, 1 Rt, 2 $31, 3 $26 (Xp)
RegWr  out  1  register-file write enable
ALUSrc1  out  1  1 = ALU A is Shamt (sll/srl/sra)
ALUSrc2  out  1  1 = ALU B is extended immediate
ALUFun  out  6  ALU op code
Sign  out  1  1 = signed compare/overflow
MemWr  out  1  data-memory write
MemRd  out  1  data-memory read
MemToReg  out  2  0 ALU, 1 memory, 2 PC+4
EXTOp  out  1  1 = sign-extend Imm16, 0 = zero-extend
LUOp  out  1  1 = load-upper (Imm16<<16)

Behaviour:
- Field outputs are pure wiring, always valid, and are not affected by reset.
- Only state is irq_q. It samples IRQ on each rising clk edge and clears asynchronously on reset.
- An interrupt is taken when irq_q=1 and PC=0, one cycle after IRQ rises.
- While reset=1: RegWr, MemWr and MemRd are forced 0 and PCSrc is forced 0. Other outputs stay combinational.
- Decode priority, highest first: reset, interrupt, exception, normal decode.
- Interrupt: PCSrc=4, RegDst=3, MemToReg=2, RegWr=1, MemWr=0, MemRd=0.
- Exception (undefined opcode/funct, PC=0): PCSrc=5, RegDst=3, MemToReg=2, RegWr=1, MemWr=0, MemRd=0.
- Undefined instruction with PC=1: no state change. RegWr=MemWr=MemRd=0, PCSrc=0.
- ALUFun codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
- R-type (op 000000), by funct:
  - add/addu/sub/subu/and/or/xor/nor/slt/sltu (20,21,22,23,24,25,26,27,2A,2B): RegDst=0, RegWr=1.
  - Sign=1 for add/sub/slt; Sign=0 for addu/subu/sltu.
  - sll/srl/sra (00,02,03): ALUSrc1=1.
  - jr (08): PCSrc=3, RegWr=0.
  - jalr (09): PCSrc=3, RegDst=0, MemToReg=2, RegWr=1.
- I-type:
  - addi/addiu: ADD, Sign 1/0, EXTOp=1.
  - andi: AND, EXTOp=0.
  - slti/sltiu: LT, Sign 1/0, EXTOp=1.
  - All of the above: ALUSrc2=1, RegDst=1, RegWr=1.
  - lw: ADD, ALUSrc2=1, MemRd=1, MemToReg=1, RegDst=1, RegWr=1.
  - sw: ADD, ALUSrc2=1, MemWr=1, RegWr=0.
  - lui: LUOp=1, ALUSrc2=1, ALUFun=ADD with A=$0, RegDst=1, RegWr=1.
- Branches: PCSrc=1 (datapath qualifies with ALU zero/result), RegWr=0, Sign=1.
  - beq EQ, bne NEQ, blez LEZ, bgtz GTZ, bltz (op 000001) LTZ.
- j: PCSrc=2. jal: PCSrc=2, RegDst=2, MemToReg=2, RegWr=1.
- Defaults for unspecified signals: 0 (ALUFun ADD, EXTOp 1).
- nop (all zero) decodes as sll $0, which is harmless.

Decomposition:
- Package cpu_ctrl_pkg: opcode/funct constants, ALUFun codes, PCSrc/RegDst/MemToReg enums, vector addresses.
- One sub-module, cpu_decode: combinational decode. The top module adds irq_q, reset gating and interrupt/exception priority.

Test Plan:
- reset=1, any instruction (e.g. lw) -> RegWr=MemWr=MemRd=0, PCSrc=0; release -> normal lw decode.
- 0x01E39020 (add $18,$15,$3) -> Rs=15, Rt=3, Rd=18, RegDst=0, RegWr=1, ALUFun=000000, Sign=1; funct 21 -> Sign=0; sll shamt1 -> ALUSrc1=1, ALUFun=100000.
- lw/sw/lui/andi -> MemRd/MemToReg=1; MemWr=1 with RegWr=0; LUOp=1; EXTOp=0 with ALUFun=011000.
- beq/bne/blez/bgtz/bltz -> PCSrc=1, ALUFun 110011/110001/111101/111111/111011; j -> PCSrc=2; jal -> RegDst=2, MemToReg=2; jr/jalr -> PCSrc=3.
- 0xFFFFFFFF with PC=0 -> PCSrc=5, RegDst=3, RegWr=1; with PC=1 -> no writes, PCSrc=0.
- IRQ=1, PC=0 -> PCSrc=4 after next clk edge (not before), RegDst=3, MemToReg=2; then PC=1 -> interrupt masked, normal decode.
